// File: rtl/ms_run_ctrl.sv
// ms_run_ctrl: debounced start/stop and clear buttons driving a run/pause FSM
// with a pausable prescaler that emits a one-cycle enable tick at TICK_HZ.
module ms_run_ctrl #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 1000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_START,
    input  logic       BTN_CLR,
    output logic       EN_TICK,
    output logic       CLR,
    output logic       RUN,
    output logic [1:0] STATE
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;

    if (DIV < 2 || (CLK_HZ % TICK_HZ) != 0) begin : g_bad_div
        $error("ms_run_ctrl: CLK_HZ/TICK_HZ must be an integer >= 2");
    end

    typedef enum logic [1:0] {IDLE = 2'b00, RUNNING = 2'b01, PAUSED = 2'b10} state_t;

    state_t state, state_n;
    logic [PW-1:0] pre, pre_n;
    logic tick_n, clr_n;
    logic [1:0] s1, s2, lvl, ev;
    logic [DW-1:0] cnt [2];

    // bit 0 = start, bit 1 = clear; ev pulses on the cycle a level settles high
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1  <= '0;
            s2  <= '0;
            lvl <= '0;
            ev  <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            s1 <= {BTN_CLR, BTN_START};
            s2 <= s1;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] != lvl[i] && cnt[i] == DW'(DB_CYCLES - 1)) begin
                    lvl[i] <= s2[i];
                    cnt[i] <= '0;
                    ev[i]  <= s2[i];
                end else begin
                    cnt[i] <= (s2[i] != lvl[i]) ? cnt[i] + 1'b1 : '0;
                    ev[i]  <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        pre_n   = pre;
        tick_n  = 1'b0;
        clr_n   = 1'b0;
        if (ev[1]) begin
            state_n = IDLE;
            pre_n   = '0;
            clr_n   = 1'b1;
        end else if (ev[0]) begin
            state_n = (state == RUNNING) ? PAUSED : RUNNING;
        end else if (state == RUNNING) begin
            tick_n = (pre == PW'(DIV - 1));
            pre_n  = tick_n ? '0 : pre + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            pre     <= '0;
            EN_TICK <= 1'b0;
            CLR     <= 1'b0;
        end else begin
            state   <= state_n;
            pre     <= pre_n;
            EN_TICK <= tick_n;
            CLR     <= clr_n;
        end
    end

    assign RUN   = (state == RUNNING);
    assign STATE = state;
endmodule

// File: tb/tb_ms_run_ctrl.sv
// tb_ms_run_ctrl: directed scenarios plus random button/reset traffic, every
// cycle compared against a behavioural model of the controller.
module tb_ms_run_ctrl;
    localparam int DIV = 4;
    localparam int DB  = 4;

    logic clk = 1'b0, rst = 1'b1, btn_start = 1'b0, btn_clr = 1'b0;
    logic en_tick, clr, run;
    logic [1:0] state;
    int checks = 0, errors = 0;

    ms_run_ctrl #(.CLK_HZ(8), .TICK_HZ(2), .DB_CYCLES(DB)) dut (
        .CLK(clk), .RST(rst), .BTN_START(btn_start), .BTN_CLR(btn_clr),
        .EN_TICK(en_tick), .CLR(clr), .RUN(run), .STATE(state)
    );

    always #5 clk = ~clk;

    // model: raw buttons reach the debouncer two cycles late; a level is
    // accepted once the last DB synchronized samples all disagree with it
    bit [1:0] m_dly[$];
    bit [1:0] m_hist[$];
    bit [1:0] m_lvl, m_ev;
    int m_mode, m_elapsed;
    bit m_tick, m_clr;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_dly  = {2'b00, 2'b00};
        m_hist = {};
        for (int i = 0; i < DB; i++) m_hist.push_back(2'b00);
        m_lvl = 0; m_ev = 0; m_mode = 0; m_elapsed = 0; m_tick = 0; m_clr = 0;
    endtask

    task automatic model_edge();
        bit [1:0] cur, nev;
        bit differ;
        if (rst) begin
            model_reset();
            return;
        end
        m_tick = 0;
        m_clr  = 0;
        if (m_ev[1]) begin
            m_mode = 0; m_elapsed = 0; m_clr = 1;
        end else if (m_ev[0]) begin
            m_mode = (m_mode == 1) ? 2 : 1;
        end else if (m_mode == 1) begin
            m_elapsed++;
            m_tick = (m_elapsed % DIV == 0);
        end
        cur = m_dly.pop_front();
        m_dly.push_back({btn_clr, btn_start});
        m_hist.pop_front();
        m_hist.push_back(cur);
        nev = 0;
        for (int i = 0; i < 2; i++) begin
            differ = 1;
            foreach (m_hist[k]) if (m_hist[k][i] == m_lvl[i]) differ = 0;
            if (differ) begin
                m_lvl[i] = cur[i];
                nev[i]   = cur[i];
            end
        end
        m_ev = nev;
    endtask

    task automatic step(input bit r, input bit bs, input bit bc);
        rst = r; btn_start = bs; btn_clr = bc;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("state", state, m_mode);
        chk("run", run, m_mode == 1);
        chk("en_tick", en_tick, m_tick);
        chk("clr", clr, m_clr);
    endtask

    task automatic hold(input bit r, input bit bs, input bit bc, input int n);
        for (int i = 0; i < n; i++) step(r, bs, bc);
    endtask

    int ticks_seen;

    initial begin
        model_reset();
        hold(1, 0, 0, 3);
        // bounce without four stable highs: no event
        step(0, 1, 0); step(0, 1, 0); step(0, 0, 0); step(0, 1, 0);
        step(0, 1, 0); step(0, 1, 0); step(0, 0, 0);
        hold(0, 0, 0, 10);
        chk("bounce_idle", state, 0);
        // held start: exactly one transition, periodic ticks
        hold(0, 1, 0, 12);
        ticks_seen = 0;
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 0);
            ticks_seen += en_tick;
        end
        chk("tick_count", ticks_seen, 4);
        // pause then resume
        hold(0, 1, 0, 6);
        hold(0, 0, 0, 20);
        hold(0, 1, 0, 6);
        hold(0, 0, 0, 12);
        // simultaneous start and clear: clear wins
        hold(0, 1, 1, 7);
        hold(0, 0, 0, 12);
        chk("clr_wins", state, 0);
        // reset pulse mid-run, then fresh start
        hold(0, 1, 0, 6);
        hold(0, 0, 0, 5);
        step(1, 0, 0);
        chk("rst_state", state, 0);
        hold(0, 1, 0, 6);
        hold(0, 0, 0, 14);
        // clear while paused, then start
        hold(0, 1, 0, 6);
        hold(0, 0, 0, 6);
        hold(0, 0, 1, 6);
        hold(0, 0, 0, 6);
        hold(0, 1, 0, 6);
        hold(0, 0, 0, 14);
        // reset with start held: one press after debounce
        hold(1, 1, 0, 2);
        hold(0, 1, 0, 10);
        chk("held_through_rst", state, 1);
        hold(0, 0, 0, 4);
        // random traffic
        for (int seg = 0; seg < 300; seg++) begin
            bit r, bs, bc;
            r  = ($urandom_range(0, 39) == 0);
            bs = ($urandom_range(0, 2) != 0);
            bc = ($urandom_range(0, 5) == 0);
            hold(r, bs, bc, r ? 1 : $urandom_range(1, 9));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ms_run_ctrl.md
MS_RUN_CTRL -- requirements
Module: ms_run_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1000, enable-tick rate in Hz; DIV = CLK_HZ/TICK_HZ.
REQ-003 Parameter DB_CYCLES, default 1_000_000, consecutive stable cycles required to accept a button level change.
REQ-004 CLK  input  1  system clock; all state changes on its rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 BTN_START  input  1  raw asynchronous start/stop pushbutton, active-high.
REQ-007 BTN_CLR  input  1  raw asynchronous clear pushbutton, active-high.
REQ-008 EN_TICK  output  1  registered one-cycle enable pulse at TICK_HZ while running; drives En of downstream count registers.
REQ-009 CLR  output  1  registered one-cycle clear pulse to downstream count registers.
REQ-010 RUN  output  1  high exactly while STATE = RUNNING.
REQ-011 STATE  output  2  current FSM state: IDLE=00, RUNNING=01, PAUSED=10; 11 never produced.

Function
REQ-012 Each button SHALL pass through its own 2-flop synchronizer before any other logic.
REQ-013 Each button SHALL have a debounced level register that changes only after the synchronized input has differed from it for DB_CYCLES consecutive cycles; any intervening match restarts that button's count at 0.
REQ-014 A press event SHALL be a one-cycle pulse on the 0->1 transition of a debounced level; the 1->0 transition produces no event.
REQ-015 FSM transitions, taken on the edge after a press event: IDLE + start -> RUNNING; RUNNING + start -> PAUSED; PAUSED + start -> RUNNING.
REQ-016 A clear event in any state SHALL move the FSM to IDLE, zero the prescaler, and assert CLR for exactly one cycle on that same edge.
REQ-017 Start and clear events in the same cycle: clear SHALL win; result is IDLE with one CLR pulse.
REQ-018 Prescaler: ceil(log2(DIV))-bit counter, 0..DIV-1; increments only in RUNNING; wraps DIV-1 -> 0.
REQ-019 EN_TICK SHALL be high in the cycle following the wrap edge; it is low at all other times and never high in IDLE or PAUSED.
REQ-020 Entering RUNNING from IDLE: the prescaler is 0, and the first EN_TICK occurs DIV cycles after the first cycle with RUN=1.
REQ-021 PAUSED SHALL hold the prescaler value; on resume, the next EN_TICK occurs after the remaining DIV-1-count cycles, so partial periods are not lost.
REQ-022 A held button SHALL produce exactly one event; auto-repeat is not allowed.
REQ-023 DIV < 2, or CLK_HZ not divisible by TICK_HZ, SHALL be an elaboration error.

Reset
REQ-024 While RST=1 at a clock edge: STATE=IDLE, RUN=0, EN_TICK=0, CLR=0, and the prescaler, debounce counters, debounced levels and synchronizer flops all equal 0.
REQ-025 RST SHALL take priority over all events, including reset asserted mid-RUNNING or mid-debounce; no CLR pulse is generated by reset.
REQ-026 After RST deasserts with a button already held high, one press event SHALL occur once that button is debounced.

Verification (CLK_HZ=8, TICK_HZ=2 -> DIV=4; DB_CYCLES=4)
REQ-027 Reset, then BTN_START high for 12 cycles -> exactly one transition to RUNNING; EN_TICK pulses at cycles 4, 8, 12... after RUN rises, each pulse 1 cycle wide.
REQ-028 BTN_START pattern 1,1,0,1,1,1,0 (no run of 4 highs) -> no event; STATE stays 00.
REQ-029 Running, second start press with prescaler at 2 -> STATE=10, EN_TICK stays 0 for 20 cycles; third press -> STATE=01, next EN_TICK 2 cycles after RUN rises.
REQ-030 Running, start and clear debounced on the same cycle -> STATE=00, CLR high for exactly 1 cycle, no further EN_TICK.
REQ-031 RST pulsed for 1 cycle mid-RUNNING -> next cycle STATE=00, RUN=0, EN_TICK=0, CLR=0; a fresh start gives the first tick after 4 cycles.
REQ-032 Clear in PAUSED, then start -> first EN_TICK exactly 4 cycles after RUN rises, which confirms the prescaler was zeroed.
